regfile_wr_scheduler: RTL and testbench

REGFILE_WR_SCHEDULER -- requirements
Module: regfile_wr_scheduler

---
 rtl/regfile_wr_scheduler_pkg.sv | 31 +++
 rtl/regfile_wr_scheduler_rr_arbiter3.sv | 38 +++
 rtl/regfile_wr_scheduler.sv | 163 ++++++++++++++++
 tb/tb_regfile_wr_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_scheduler_pkg.sv
// Shared definitions for the register-file write scheduler.
//   DATA_W / ADDR_W : register data and address widths
//   N_REQ           : number of write requesters
//   NUM_REGS        : registers zeroed by a clear sequence
//   state_t         : scheduler FSM encodings (NORMAL / CLEAR)
//   next_ptr()      : round-robin pointer that follows a one-hot grant
package regfile_wr_scheduler_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int N_REQ    = 3;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        CLEAR  = 1'b1
    } state_t;

    // The requester after the granted one becomes the new search start.
    function automatic logic [1:0] next_ptr(input logic [N_REQ-1:0] grant);
        logic [1:0] p;
        case (grant)
            3'b001:  p = 2'd1;
            3'b010:  p = 2'd2;
            3'b100:  p = 2'd0;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/regfile_wr_scheduler_rr_arbiter3.sv
// Three-way round-robin arbiter (purely combinational).
//   req   : request vector, bit i = requester i
//   ptr   : requester index the search starts from (0..2)
//   grant : one-hot grant to the first requester at or after ptr, or zero
module rr_arbiter3
    import regfile_wr_scheduler_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [N_REQ-1:0] grant
);

    // Priority search P, P+1, P+2 (mod 3); an out-of-range ptr searches from 0.
    always_comb begin
        grant = 3'b000;
        case (ptr)
            2'd1: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else             grant = 3'b000;
            end
            2'd2: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else             grant = 3'b000;
            end
            default: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else             grant = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/regfile_wr_scheduler.sv
// Schedules register-file writes from three requesters, plus a clear
// sequence that zeroes all registers through the same write port.
//   Clk, Reset            : rising-edge clock, async active-high reset
//   Req_Valid/Addr/Data   : per-requester write requests (packed per requester)
//   Req_Ready             : combinational one-hot accept
//   Clear_Start           : one-cycle request to start a clear sequence
//   Clear_Done            : pulse with the final (address 31) clear write
//   Busy                  : clear sequence in progress
//   Write_Reg/W_Addr/W_Data : registered register-file write port
module regfile_wr_scheduler
    import regfile_wr_scheduler_pkg::*;
#(
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [N_REQ-1:0]        Req_Valid,
    input  logic [N_REQ*ADDR_W-1:0] Req_Addr,
    input  logic [N_REQ*DATA_W-1:0] Req_Data,
    output logic [N_REQ-1:0]        Req_Ready,
    input  logic                    Clear_Start,
    output logic                    Clear_Done,
    output logic                    Busy,
    output logic                    Write_Reg,
    output logic [ADDR_W-1:0]       W_Addr,
    output logic [DATA_W-1:0]       W_Data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t             state_r, state_nx_s;
    logic [1:0]         ptr_r, ptr_nx_s;
    logic [ADDR_W-1:0]  cnt_r, cnt_nx_s;
    logic               write_reg_r, write_reg_nx_s;
    logic [ADDR_W-1:0]  w_addr_r, w_addr_nx_s;
    logic [DATA_W-1:0]  w_data_r, w_data_nx_s;
    logic               clear_done_r, clear_done_nx_s;
    logic [N_REQ-1:0]   grant_s;
    logic [N_REQ-1:0]   ready_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               xfer_s;

    rr_arbiter3 u_arb (
        .req   (Req_Valid),
        .ptr   (ptr_r),
        .grant (grant_s)
    );

    // Accept only in NORMAL; a simultaneous Clear_Start takes precedence.
    always_comb begin
        ready_s = 3'b000;
        if (!Reset && (state_r == NORMAL) && !Clear_Start) begin
            ready_s = grant_s & Req_Valid;
        end else begin
            ready_s = 3'b000;
        end
    end

    assign xfer_s    = |ready_s;
    assign Req_Ready = ready_s;
    assign Busy      = (state_r == CLEAR) && !Reset;

    // Route the accepted requester's address and data.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        case (ready_s)
            3'b001: begin
                sel_addr_s = Req_Addr[4:0];
                sel_data_s = Req_Data[31:0];
            end
            3'b010: begin
                sel_addr_s = Req_Addr[9:5];
                sel_data_s = Req_Data[63:32];
            end
            3'b100: begin
                sel_addr_s = Req_Addr[14:10];
                sel_data_s = Req_Data[95:64];
            end
            default: begin
                sel_addr_s = '0;
                sel_data_s = '0;
            end
        endcase
    end

    // Next-state, pointer, clear counter and write-port values.
    always_comb begin
        state_nx_s      = state_r;
        ptr_nx_s        = ptr_r;
        cnt_nx_s        = cnt_r;
        write_reg_nx_s  = 1'b0;
        w_addr_nx_s     = w_addr_r;
        w_data_nx_s     = w_data_r;
        clear_done_nx_s = 1'b0;
        case (state_r)
            NORMAL: begin
                if (Clear_Start) begin
                    state_nx_s = CLEAR;
                    cnt_nx_s   = '0;
                end else if (xfer_s) begin
                    ptr_nx_s = next_ptr(ready_s);
                    // Protected address-0 writes are consumed silently and
                    // leave the write port's address/data untouched.
                    if (!(ZERO_PROTECT && (sel_addr_s == 5'd0))) begin
                        write_reg_nx_s = 1'b1;
                        w_addr_nx_s    = sel_addr_s;
                        w_data_nx_s    = sel_data_s;
                    end else begin
                        write_reg_nx_s = 1'b0;
                    end
                end else begin
                    write_reg_nx_s = 1'b0;
                end
            end
            CLEAR: begin
                write_reg_nx_s = 1'b1;
                w_addr_nx_s    = cnt_r;
                w_data_nx_s    = 32'h0000_0000;
                // Terminate on the last register; the counter never wraps.
                if (cnt_r == LAST_ADDR) begin
                    state_nx_s      = NORMAL;
                    clear_done_nx_s = 1'b1;
                    cnt_nx_s        = '0;
                end else begin
                    cnt_nx_s = cnt_r + 5'd1;
                end
            end
            default: begin
                state_nx_s = NORMAL;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r      <= NORMAL;
            ptr_r        <= 2'd0;
            cnt_r        <= '0;
            write_reg_r  <= 1'b0;
            w_addr_r     <= '0;
            w_data_r     <= '0;
            clear_done_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            ptr_r        <= ptr_nx_s;
            cnt_r        <= cnt_nx_s;
            write_reg_r  <= write_reg_nx_s;
            w_addr_r     <= w_addr_nx_s;
            w_data_r     <= w_data_nx_s;
            clear_done_r <= clear_done_nx_s;
        end
    end

    assign Write_Reg  = write_reg_r;
    assign W_Addr     = w_addr_r;
    assign W_Data     = w_data_r;
    assign Clear_Done = clear_done_r;

endmodule

// File: tb/tb_regfile_wr_scheduler.sv
module tb_regfile_wr_scheduler;

    logic        Clk;
    logic        Reset;
    logic [2:0]  Req_Valid;
    logic [14:0] Req_Addr;
    logic [95:0] Req_Data;
    logic [2:0]  Req_Ready;
    logic        Clear_Start;
    logic        Clear_Done;
    logic        Busy;
    logic        Write_Reg;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;

    int checks;
    int failures;

    regfile_wr_scheduler #(.ZERO_PROTECT(1'b1)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req_Valid   (Req_Valid),
        .Req_Addr    (Req_Addr),
        .Req_Data    (Req_Data),
        .Req_Ready   (Req_Ready),
        .Clear_Start (Clear_Start),
        .Clear_Done  (Clear_Done),
        .Busy        (Busy),
        .Write_Reg   (Write_Reg),
        .W_Addr      (W_Addr),
        .W_Data      (W_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  v;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  er;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
    } vec_t;

    vec_t vec[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    localparam logic [31:0] DA = 32'h1000_0000;
    localparam logic [31:0] DB = 32'h1111_1111;
    localparam logic [31:0] DC = 32'h2222_2222;

    initial begin
        checks = 0;
        failures = 0;
        Reset = 1'b1;
        Req_Valid = 3'b111;
        Req_Addr = '0;
        Req_Data = '0;
        Clear_Start = 1'b0;

        //           v       a0     a1     a2     d0            d1            d2            er      ew    ea     ed
        vec[0]  = '{3'b111, 5'd1,  5'd2,  5'd3,  DA,           DB,           DC,           3'b001, 1'b1, 5'd1,  DA};
        vec[1]  = '{3'b111, 5'd1,  5'd2,  5'd3,  DA,           DB,           DC,           3'b010, 1'b1, 5'd2,  DB};
        vec[2]  = '{3'b111, 5'd1,  5'd2,  5'd3,  DA,           DB,           DC,           3'b100, 1'b1, 5'd3,  DC};
        vec[3]  = '{3'b111, 5'd1,  5'd2,  5'd3,  DA,           DB,           DC,           3'b001, 1'b1, 5'd1,  DA};
        vec[4]  = '{3'b111, 5'd1,  5'd2,  5'd3,  DA,           DB,           DC,           3'b010, 1'b1, 5'd2,  DB};
        vec[5]  = '{3'b111, 5'd1,  5'd2,  5'd3,  DA,           DB,           DC,           3'b100, 1'b1, 5'd3,  DC};
        vec[6]  = '{3'b010, 5'd0,  5'd7,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        3'b010, 1'b1, 5'd7,  32'hDEADBEEF};
        vec[7]  = '{3'b100, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h55555555, 3'b100, 1'b0, 5'd7,  32'hDEADBEEF};
        vec[8]  = '{3'b101, 5'd9,  5'd0,  5'd4,  32'hCAFEF00D, 32'h0,        32'h44444444, 3'b001, 1'b1, 5'd9,  32'hCAFEF00D};
        vec[9]  = '{3'b000, 5'd3,  5'd3,  5'd3,  32'h1,        32'h2,        32'h3,        3'b000, 1'b0, 5'd9,  32'hCAFEF00D};
        vec[10] = '{3'b101, 5'd9,  5'd0,  5'd12, 32'h9,        32'h0,        32'h12345678, 3'b100, 1'b1, 5'd12, 32'h12345678};
        vec[11] = '{3'b110, 5'd0,  5'd5,  5'd6,  32'h0,        32'h55,       32'h66,       3'b010, 1'b1, 5'd5,  32'h55};
        vec[12] = '{3'b011, 5'd8,  5'd5,  5'd0,  32'h88,       32'h55,       32'h0,        3'b001, 1'b1, 5'd8,  32'h88};

        // Reset state
        #12;
        chk("rst_ready", {29'd0, Req_Ready}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_wr", {31'd0, Write_Reg}, 32'd0);
        chk("rst_waddr", {27'd0, W_Addr}, 32'd0);
        chk("rst_wdata", W_Data, 32'd0);
        chk("rst_done", {31'd0, Clear_Done}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        Req_Valid = 3'b000;

        // Table-driven arbitration / write-port vectors
        for (int i = 0; i < 13; i++) begin
            @(negedge Clk);
            Req_Valid = vec[i].v;
            Req_Addr  = {vec[i].a2, vec[i].a1, vec[i].a0};
            Req_Data  = {vec[i].d2, vec[i].d1, vec[i].d0};
            #1;
            chk($sformatf("v%0d_ready", i), {29'd0, Req_Ready}, {29'd0, vec[i].er});
            @(posedge Clk);
            #1;
            chk($sformatf("v%0d_wr", i), {31'd0, Write_Reg}, {31'd0, vec[i].ew});
            chk($sformatf("v%0d_waddr", i), {27'd0, W_Addr}, {27'd0, vec[i].ea});
            chk($sformatf("v%0d_wdata", i), W_Data, vec[i].ed);
        end
        // Pointer is now 1.

        // Clear with requesters 0 and 2 valid, plus an ignored second Clear_Start
        @(negedge Clk);
        Req_Valid = 3'b101;
        Req_Addr = {5'd20, 5'd0, 5'd21};
        Req_Data = {32'hABCD0001, 32'h0, 32'hABCD0000};
        Clear_Start = 1'b1;
        #1;
        chk("clr_pulse_ready", {29'd0, Req_Ready}, 32'd0);
        chk("clr_pulse_busy", {31'd0, Busy}, 32'd0);
        @(posedge Clk);
        #1;
        chk("clr_first_wr", {31'd0, Write_Reg}, 32'd0);
        for (int k = 0; k < 32; k++) begin
            @(negedge Clk);
            Clear_Start = (k == 5) ? 1'b1 : 1'b0;
            #1;
            chk($sformatf("clr%0d_ready", k), {29'd0, Req_Ready}, 32'd0);
            chk($sformatf("clr%0d_busy", k), {31'd0, Busy}, 32'd1);
            @(posedge Clk);
            #1;
            chk($sformatf("clr%0d_wr", k), {31'd0, Write_Reg}, 32'd1);
            chk($sformatf("clr%0d_waddr", k), {27'd0, W_Addr}, k);
            chk($sformatf("clr%0d_wdata", k), W_Data, 32'd0);
            chk($sformatf("clr%0d_done", k), {31'd0, Clear_Done}, (k == 31) ? 32'd1 : 32'd0);
        end
        // Clear_Done cycle: back in NORMAL and grantable, pointer still 1
        chk("clr_end_busy", {31'd0, Busy}, 32'd0);
        @(negedge Clk);
        #1;
        chk("clr_resume_ready", {29'd0, Req_Ready}, 32'd4);
        @(posedge Clk);
        #1;
        chk("clr_resume_wr", {31'd0, Write_Reg}, 32'd1);
        chk("clr_resume_waddr", {27'd0, W_Addr}, 32'd20);
        chk("clr_resume_wdata", W_Data, 32'hABCD0001);
        chk("clr_resume_done", {31'd0, Clear_Done}, 32'd0);
        // Pointer is now 0; move it to 1 with a requester-0 write.
        @(negedge Clk);
        Req_Valid = 3'b001;
        @(posedge Clk);
        #1;
        chk("pre_abort_waddr", {27'd0, W_Addr}, 32'd21);

        // Reset asserted when the clear write to address 10 is registered
        @(negedge Clk);
        Req_Valid = 3'b000;
        Clear_Start = 1'b1;
        @(negedge Clk);
        Clear_Start = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(posedge Clk);
            #1;
            chk($sformatf("abort%0d_waddr", k), {27'd0, W_Addr}, k);
        end
        #1;
        Reset = 1'b1;
        Req_Valid = 3'b111;
        #1;
        chk("abort_wr", {31'd0, Write_Reg}, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_ready", {29'd0, Req_Ready}, 32'd0);
        chk("abort_waddr0", {27'd0, W_Addr}, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        Req_Valid = 3'b000;
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 25; k++) begin
                @(posedge Clk);
                #1;
                if (Write_Reg !== 1'b0 || Clear_Done !== 1'b0 || Busy !== 1'b0) bad++;
            end
            chk("abort_quiet_cycles", bad, 32'd0);
        end
        @(negedge Clk);
        Req_Valid = 3'b111;
        Req_Addr = {5'd3, 5'd2, 5'd1};
        #1;
        chk("abort_grant_req0", {29'd0, Req_Ready}, 32'd1);
        @(posedge Clk);
        #1;
        chk("abort_grant_waddr", {27'd0, W_Addr}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
